// File: rtl/simon_6496_host_driver.sv
// rtl/simon_6496_host_driver.sv - host-side initiator for the SIMON 64/96 core handshake
//
// Purpose:
//   Collects N-bit words from a valid/ready input stream into KEY (M words) or
//   BLOCK (2 words), runs the core key-load / data-load handshakes with a
//   per-state timeout, and returns the core result as a 2-word valid/ready
//   output stream. One transaction is in flight at a time.
//
// Ports:
//   clk, R                  clock, synchronous active-high reset
//   in_valid/in_ready       input word handshake; in_sel 0=key 1=data,
//   in_sel/in_dec/in_word   in_dec sampled with the final data word
//   out_valid/out_ready     result word handshake, outData[0] then outData[1]
//   out_word
//   key_ok, busy, err       status; err is sticky until clr_err in S_ERR
//   clr_err                 error clear
//   newKey/newData          core requests, held until loadKey/loadData
//   enc_dec, readData       core direction, 1-cycle result acknowledge
//   KEY, BLOCK              core key/block registers
//   loadKey/doneKey         core key handshake
//   loadData/doneData       core data handshake
//   outData                 core result block
module simon_6496_host_driver #(
  parameter int N       = 32,
  parameter int M       = 3,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                R,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sel,
  input  logic                in_dec,
  input  logic [N-1:0]        in_word,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        out_word,
  output logic                key_ok,
  output logic                busy,
  output logic                err,
  input  logic                clr_err,
  output logic                newKey,
  output logic                newData,
  output logic                enc_dec,
  output logic                readData,
  output logic [M-1:0][N-1:0] KEY,
  output logic [1:0][N-1:0]   BLOCK,
  input  logic                loadKey,
  input  logic                doneKey,
  input  logic                loadData,
  input  logic                doneData,
  input  logic [1:0][N-1:0]   outData
);

  localparam int KW = (M > 1) ? $clog2(M) : 1;
  localparam logic [KW-1:0]   K_LAST = KW'(M - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_KEY_REQ, S_KEY_RUN, S_DATA_REQ, S_DATA_RUN, S_OUT, S_ERR
  } state_t;

  state_t            state, state_n;
  logic [KW-1:0]     kcnt;
  logic              dcnt;
  logic              ocnt;
  logic [TO_W-1:0]   tcnt;
  logic              done_seen;
  logic [1:0][N-1:0] res;
  logic              acc_key, acc_data;
  logic              waiting, to_hit;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign newKey    = (state == S_KEY_REQ);
  assign newData   = (state == S_DATA_REQ);
  assign out_valid = (state == S_OUT);
  assign out_word  = res[ocnt];

  assign waiting = (state == S_KEY_REQ) || (state == S_KEY_RUN) ||
                   (state == S_DATA_REQ) || (state == S_DATA_RUN);
  // Fires in the last allowed cycle so err rises exactly TIMEOUT cycles after entry.
  assign to_hit  = waiting && (tcnt == TO_LAST);

  always_comb begin
    state_n  = state;
    acc_key  = 1'b0;
    acc_data = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          if (!in_sel) begin
            acc_key = 1'b1;
            if (kcnt == K_LAST) state_n = S_KEY_REQ;
          end else begin
            acc_data = 1'b1;
            if (dcnt) state_n = key_ok ? S_DATA_REQ : S_ERR;
          end
        end
      end
      S_KEY_REQ: begin
        if (loadKey)     state_n = S_KEY_RUN;
        else if (to_hit) state_n = S_ERR;
      end
      S_KEY_RUN: begin
        if (doneKey || done_seen) state_n = S_IDLE;
        else if (to_hit)          state_n = S_ERR;
      end
      S_DATA_REQ: begin
        if (loadData)    state_n = S_DATA_RUN;
        else if (to_hit) state_n = S_ERR;
      end
      S_DATA_RUN: begin
        if (doneData || done_seen) state_n = S_OUT;
        else if (to_hit)           state_n = S_ERR;
      end
      S_OUT: begin
        if (out_ready && ocnt) state_n = S_IDLE;
      end
      S_ERR: begin
        if (clr_err) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state     <= S_IDLE;
      kcnt      <= '0;
      dcnt      <= 1'b0;
      ocnt      <= 1'b0;
      tcnt      <= '0;
      done_seen <= 1'b0;
      res       <= '0;
      KEY       <= '0;
      BLOCK     <= '0;
      enc_dec   <= 1'b0;
      readData  <= 1'b0;
      key_ok    <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_n;

      if (state_n != state) tcnt <= '0;
      else if (waiting)     tcnt <= tcnt + TO_W'(1);

      // A done seen while still requesting is carried into the RUN state.
      if (state == S_KEY_REQ)       done_seen <= done_seen | doneKey;
      else if (state == S_DATA_REQ) done_seen <= done_seen | doneData;
      else                          done_seen <= 1'b0;

      if (acc_key) begin
        KEY[kcnt] <= in_word;
        kcnt      <= (kcnt == K_LAST) ? '0 : kcnt + KW'(1);
        dcnt      <= 1'b0;
        key_ok    <= 1'b0;
      end

      if (acc_data) begin
        BLOCK[dcnt] <= in_word;
        dcnt        <= ~dcnt;
        if (dcnt) enc_dec <= in_dec;
      end

      if (state == S_KEY_RUN && state_n == S_IDLE) key_ok <= 1'b1;

      readData <= (state == S_DATA_RUN) && (state_n == S_OUT);
      if (state == S_DATA_RUN && state_n == S_OUT) begin
        res  <= outData;
        ocnt <= 1'b0;
      end

      if (state == S_OUT && out_ready) ocnt <= ~ocnt;

      if (state_n == S_ERR && state != S_ERR) begin
        err    <= 1'b1;
        key_ok <= 1'b0;
      end

      if (state == S_ERR && clr_err) begin
        err  <= 1'b0;
        kcnt <= '0;
        dcnt <= 1'b0;
        ocnt <= 1'b0;
      end
    end
  end

endmodule
